// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: constants and the queue entry type shared by the PC register, fetch and decode
package fetch_unit_pkg;
  localparam int INSTR_W = 32;
  localparam logic [31:0] PC_INC = 32'd4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;
  typedef struct packed {
    logic [31:0] pc;
    logic [INSTR_W-1:0] instr;
  } fq_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular in-order FIFO of fetched {pc, instr} with flush and same-cycle enq/deq
module fetch_queue import fetch_unit_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     enq,
  input  fq_entry_t                enq_data,
  input  logic                     deq,
  output fq_entry_t                deq_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  fq_entry_t mem [DEPTH];
  logic [AW-1:0] head, tail;
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        mem[tail] <= enq_data;
        tail      <= tail + AW'(1);
      end
      if (deq) head <= head + AW'(1);
      count <= count + CW'(enq) - CW'(deq);
    end
  end
  assign deq_data = (count != '0) ? mem[head] : '0;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetches at pc_current into the queue, drives PC next/write with stall and redirect
module fetch_unit import fetch_unit_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              pc_current,
  output logic [31:0]              pc_next,
  output logic                     pc_write,
  output logic [31:0]              imem_addr,
  input  logic [INSTR_W-1:0]       imem_rdata,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [INSTR_W-1:0]       deq_instr,
  output logic [31:0]              deq_pc,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic deq_fire, enq_ok, live;
  fq_entry_t wr, head;
  assign imem_addr = pc_current;
  assign deq_valid = count != '0;
  assign deq_fire  = deq_valid & deq_ready;
  assign enq_ok    = (count != CW'(DEPTH)) | deq_fire;
  assign live      = !reset & !redirect_valid;
  assign wr        = '{pc: pc_current, instr: imem_rdata};
  always_comb pc_next = reset ? pc_current : redirect_valid ? redirect_pc : enq_ok ? pc_current + PC_INC : pc_current;
  assign pc_write  = !reset & (redirect_valid | enq_ok);
  fetch_queue #(.DEPTH(DEPTH)) u_q (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect_valid),
    .enq      (live & enq_ok),
    .enq_data (wr),
    .deq      (live & deq_fire),
    .deq_data (head),
    .count    (count)
  );
  assign deq_instr = head.instr;
  assign deq_pc    = head.pc;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random and directed stimulus against a queue-based reference model of fetch_unit
module tb_fetch_unit;
  localparam int DEPTH = 4;
  localparam logic [31:0] KEY = 32'hA5A5A5A5;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;
  logic clk = 0, reset, redirect_valid, deq_ready, pc_write, deq_valid;
  logic [31:0] pc_current, pc_next, imem_addr, imem_rdata, redirect_pc, deq_instr, deq_pc;
  logic [2:0] count;
  int checks = 0, errors = 0;
  bit known = 0;
  ent_t mq[$];
  always #5 clk = ~clk;
  assign imem_rdata = imem_addr ^ KEY;
  fetch_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .pc_current(pc_current), .pc_next(pc_next), .pc_write(pc_write),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .deq_valid(deq_valid), .deq_ready(deq_ready),
    .deq_instr(deq_instr), .deq_pc(deq_pc), .count(count)
  );
  always @(posedge clk) pc_current <= reset ? 32'h0 : pc_write ? pc_next : pc_current;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  always @(negedge clk) begin
    bit has, ok;
    has = mq.size() != 0;
    ok = mq.size() < DEPTH || (has && deq_ready);
    if (known) begin
      chk("count", 32'(count), 32'(mq.size()));
      chk("deq_valid", 32'(deq_valid), 32'(has));
      chk("deq_pc", deq_pc, has ? mq[0].pc : 32'h0);
      chk("deq_instr", deq_instr, has ? mq[0].instr : 32'h0);
      chk("imem_addr", imem_addr, pc_current);
      chk("pc_write", 32'(pc_write), 32'(!reset && (redirect_valid || ok)));
      chk("pc_next", pc_next, reset ? pc_current : redirect_valid ? redirect_pc : ok ? pc_current + 32'd4 : pc_current);
    end
    if (reset) begin
      mq.delete();
      known = 1;
    end else if (redirect_valid) mq.delete();
    else begin
      if (has && deq_ready) void'(mq.pop_front());
      if (ok) mq.push_back('{pc: pc_current, instr: pc_current ^ KEY});
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1;
    redirect_valid = 0;
    repeat (2) cyc();
    reset = 0;
  endtask
  initial begin
    reset = 1; redirect_valid = 0; redirect_pc = 0; deq_ready = 0;
    repeat (3) cyc();
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(deq_valid), 0);
    chk("rst_deq_pc", deq_pc, 0);
    chk("rst_deq_instr", deq_instr, 0);
    #1 chk("rst_pc_write", 32'(pc_write), 0);
    reset = 0; deq_ready = 1;
    #1 chk("run_pc_next", pc_next, 32'h4);
    cyc();
    chk("lat_valid", 32'(deq_valid), 1);
    chk("lat_pc", deq_pc, 32'h0);
    chk("lat_instr", deq_instr, 32'hA5A5A5A5);
    cyc();
    chk("run_pc1", deq_pc, 32'h4);
    repeat (6) cyc();
    do_reset();
    deq_ready = 0;
    for (int i = 1; i <= DEPTH; i++) begin
      cyc();
      chk("fill_count", 32'(count), 32'(i));
    end
    #1 chk("full_pc_write", 32'(pc_write), 0);
    chk("full_pc_frozen", pc_current, 32'h10);
    cyc();
    chk("full_hold_count", 32'(count), 4);
    chk("full_hold_pc", pc_current, 32'h10);
    chk("full_head", deq_pc, 32'h0);
    deq_ready = 1;
    #1 chk("full_fire_pc_next", pc_next, 32'h14);
    cyc();
    deq_ready = 0;
    chk("full_fire_count", 32'(count), 4);
    chk("full_fire_head", deq_pc, 32'h4);
    chk("full_fire_pc", pc_current, 32'h14);
    deq_ready = 1;
    for (int i = 2; i <= 4; i++) begin
      cyc();
      chk("drain_pc", deq_pc, 32'(i * 4));
    end
    do_reset();
    deq_ready = 0;
    repeat (3) cyc();
    chk("pre_redir_count", 32'(count), 3);
    redirect_valid = 1; redirect_pc = 32'h100;
    #1 chk("redir_pc_next", pc_next, 32'h100);
    chk("redir_pc_write", 32'(pc_write), 1);
    cyc();
    redirect_valid = 0;
    chk("redir_count", 32'(count), 0);
    cyc();
    chk("redir_deq_pc", deq_pc, 32'h100);
    repeat (3) cyc();
    redirect_valid = 1; redirect_pc = 32'h200;
    cyc();
    redirect_valid = 0;
    chk("redir_full_count", 32'(count), 0);
    for (int i = 0; i < 400; i++) begin
      deq_ready = ($urandom_range(0, 3) != 0) ^ (i[6] & i[5]);
      redirect_valid = $urandom_range(0, 31) == 0;
      redirect_pc = $urandom;
      cyc();
    end
    redirect_valid = 0; deq_ready = 0;
    repeat (5) cyc();
    reset = 1; redirect_valid = 1; redirect_pc = 32'h300; deq_ready = 1;
    #1 chk("mid_rst_pc_write", 32'(pc_write), 0);
    chk("mid_rst_pc_next", pc_next, pc_current);
    cyc();
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_valid", 32'(deq_valid), 0);
    reset = 0; redirect_valid = 0;
    repeat (4) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
